// File: rtl/longest_run_pkg.sv
// Shared types and saturating arithmetic helpers for the longest-run stream tracker.
// Helpers work on a fixed 32-bit datapath; callers zero-extend and pass their own ceiling.
package longest_run_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SAT_W = 32;

    // Returns {saturated, clamped sum}; the sum never exceeds maxc.
    function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] maxc);
        logic [SAT_W:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s > {1'b0, maxc}) begin
            return {1'b1, maxc};
        end else begin
            return {1'b0, sum_s[SAT_W-1:0]};
        end
    endfunction

    function automatic logic [SAT_W-1:0] max3(input logic [SAT_W-1:0] a,
                                              input logic [SAT_W-1:0] b,
                                              input logic [SAT_W-1:0] c);
        logic [SAT_W-1:0] m_s;
        if (a > b) begin
            m_s = a;
        end else begin
            m_s = b;
        end
        if (c > m_s) begin
            m_s = c;
        end else begin
            m_s = m_s;
        end
        return m_s;
    endfunction

endpackage

// File: rtl/run_word_analyzer.sv
// Combinational run statistics of one word: leading ones (MSB side), trailing ones
// (LSB side), longest internal run and an all-ones flag.
module run_word_analyzer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic [WIDTH-1:0] d,
    output logic [CNT_W-1:0] pre,
    output logic [CNT_W-1:0] suf,
    output logic [CNT_W-1:0] wmax,
    output logic             all
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic pre_open_s;
    logic suf_open_s;
    logic [CNT_W-1:0] run_s;

    // Edge runs: count ones until the first zero from each end.
    always_comb begin
        pre        = '0;
        suf        = '0;
        pre_open_s = 1'b1;
        suf_open_s = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (pre_open_s && d[WIDTH-1-i]) begin
                pre = pre + ONE;
            end else begin
                pre_open_s = 1'b0;
            end
            if (suf_open_s && d[i]) begin
                suf = suf + ONE;
            end else begin
                suf_open_s = 1'b0;
            end
        end
    end

    // Longest run anywhere inside the word.
    always_comb begin
        run_s = '0;
        wmax  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) begin
                run_s = run_s + ONE;
            end else begin
                run_s = '0;
            end
            if (run_s > wmax) begin
                wmax = run_s;
            end else begin
                wmax = wmax;
            end
        end
    end

    assign all = &d;

endmodule

// File: rtl/longest_run_stream_tracker.sv
// Frame-level longest run of ones (or zeros) over a valid/ready word stream,
// joining runs across word boundaries; one saturating result per frame.
module longest_run_stream_tracker
    import longest_run_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             count_zeros,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_max,
    output logic             out_sat
);

    localparam logic [SAT_W-1:0] ONE_W = {{(SAT_W-1){1'b0}}, 1'b1};
    localparam logic [SAT_W-1:0] MAXC  = (CNT_W >= SAT_W) ? {SAT_W{1'b1}}
                                                          : ((ONE_W << CNT_W) - ONE_W);

    state_t           state_r;
    logic             mode_r;
    logic [CNT_W-1:0] carry_r;
    logic [CNT_W-1:0] max_r;
    logic             sat_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] out_max_r;
    logic             out_sat_r;

    logic             accept_s;
    logic             mode_s;
    logic [CNT_W-1:0] carry_s;
    logic [CNT_W-1:0] max_s;
    logic             sat_s;
    logic [WIDTH-1:0] d_s;
    logic [CNT_W-1:0] pre_s;
    logic [CNT_W-1:0] suf_s;
    logic [CNT_W-1:0] wmax_s;
    logic             all_s;
    logic [SAT_W:0]   join_s;
    logic [SAT_W:0]   cont_s;
    logic [SAT_W-1:0] best_s;
    logic [CNT_W-1:0] new_max_s;
    logic [CNT_W-1:0] new_carry_s;
    logic             beat_sat_s;

    assign in_ready  = !reset && (state_r != DONE);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign out_max   = out_max_r;
    assign out_sat   = out_sat_r;

    // The first beat of a frame takes its mode from the port and starts from empty accumulators.
    always_comb begin
        if (state_r == IDLE) begin
            mode_s  = count_zeros;
            carry_s = '0;
            max_s   = '0;
            sat_s   = 1'b0;
        end else begin
            mode_s  = mode_r;
            carry_s = carry_r;
            max_s   = max_r;
            sat_s   = sat_r;
        end
    end

    assign d_s = mode_s ? ~in_data : in_data;

    run_word_analyzer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_analyzer (
        .d    (d_s),
        .pre  (pre_s),
        .suf  (suf_s),
        .wmax (wmax_s),
        .all  (all_s)
    );

    // Fold this beat into the frame: the carried run joins the leading run of the word.
    always_comb begin
        join_s    = sat_add(SAT_W'(carry_s), SAT_W'(pre_s), MAXC);
        cont_s    = sat_add(SAT_W'(carry_s), SAT_W'(WIDTH), MAXC);
        best_s    = max3(SAT_W'(max_s), join_s[SAT_W-1:0], SAT_W'(wmax_s));
        new_max_s = best_s[CNT_W-1:0];
        if (all_s) begin
            new_carry_s = cont_s[CNT_W-1:0];
            beat_sat_s  = join_s[SAT_W] | cont_s[SAT_W];
        end else begin
            new_carry_s = suf_s;
            beat_sat_s  = join_s[SAT_W];
        end
    end

    // Frame FSM, accumulators and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mode_r      <= 1'b0;
            carry_r     <= '0;
            max_r       <= '0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_max_r   <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (accept_s) begin
                        mode_r <= mode_s;
                        if (in_last) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            out_max_r   <= new_max_s;
                            out_sat_r   <= sat_s | beat_sat_s;
                        end else begin
                            state_r <= ACCUM;
                            carry_r <= new_carry_s;
                            max_r   <= new_max_s;
                            sat_r   <= sat_s | beat_sat_s;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        mode_r      <= 1'b0;
                        carry_r     <= '0;
                        max_r       <= '0;
                        sat_r       <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    carry_r     <= '0;
                    max_r       <= '0;
                    sat_r       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_longest_run_stream_tracker.sv
// Bench: two trackers (CNT_W=16 and CNT_W=4) on shared stimulus, checked every cycle
// against a bit-queue model of each frame plus directed literal expectations.
module tb_longest_run_stream_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        count_zeros = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, in_ready4;
    logic        out_valid, out_valid4;
    logic [15:0] out_max;
    logic [3:0]  out_max4;
    logic        out_sat, out_sat4;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    longest_run_stream_tracker #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .count_zeros(count_zeros),
        .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max), .out_sat(out_sat)
    );

    longest_run_stream_tracker #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_last(in_last), .count_zeros(count_zeros),
        .out_valid(out_valid4), .out_ready(out_ready), .out_max(out_max4), .out_sat(out_sat4)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame as a plain bit list, result = longest run clamped to MAXC.
    bit   frame_bits[$];
    bit   open_m = 1'b0;
    bit   mode_m = 1'b0;
    bit   exp_valid_m = 1'b0;
    int   exp_max16 = 0, exp_max4 = 0;
    bit   exp_sat16 = 1'b0, exp_sat4 = 1'b0;

    function automatic int longest(input bit q[$]);
        int run = 0;
        int best = 0;
        foreach (q[i]) begin
            run = q[i] ? run + 1 : 0;
            if (run > best) best = run;
        end
        return best;
    endfunction

    initial begin
        int len;
        bit acc, take;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("out_valid", out_valid, exp_valid_m);
                check("out_valid4", out_valid4, exp_valid_m);
                check("in_ready", in_ready, !reset && !exp_valid_m);
                check("in_ready4", in_ready4, !reset && !exp_valid_m);
                if (exp_valid_m) begin
                    check("out_max", out_max, exp_max16);
                    check("out_sat", out_sat, exp_sat16);
                    check("out_max4", out_max4, exp_max4);
                    check("out_sat4", out_sat4, exp_sat4);
                end
            end
            acc  = !reset && in_valid && !exp_valid_m;
            take = !reset && exp_valid_m && out_ready;
            if (reset) begin
                frame_bits.delete();
                open_m = 1'b0;
                mode_m = 1'b0;
                exp_valid_m = 1'b0;
            end else if (take) begin
                exp_valid_m = 1'b0;
            end else if (acc) begin
                if (!open_m) begin
                    open_m = 1'b1;
                    mode_m = count_zeros;
                    frame_bits.delete();
                end
                for (int i = 7; i >= 0; i--) frame_bits.push_back(in_data[i] ^ mode_m);
                if (in_last) begin
                    len = longest(frame_bits);
                    exp_max16 = (len > 65535) ? 65535 : len;
                    exp_sat16 = (len > 65535);
                    exp_max4  = (len > 15) ? 15 : len;
                    exp_sat4  = (len > 15);
                    exp_valid_m = 1'b1;
                    open_m = 1'b0;
                end
            end
        end
    end

    // Drive one beat and hold it until the tracker accepts it; returns at posedge+1.
    task automatic send_beat(input logic [7:0] data, input logic last, input logic cz);
        int waited = 0;
        in_valid = 1'b1;
        in_data = data;
        in_last = last;
        count_zeros = cz;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                check("beat_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Wait for a result, check it against hand-computed values, then take it.
    task automatic get_result(input string nm, input int m16, input bit s16,
                              input int m4, input bit s4, output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            if (lat > 50) begin
                check({nm, "_timeout"}, 0, 1);
                break;
            end
        end
        check({nm, "_max"}, out_max, m16);
        check({nm, "_sat"}, out_sat, s16);
        check({nm, "_max4"}, out_max4, m4);
        check({nm, "_sat4"}, out_sat4, s4);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_out_max", out_max, 0);
        check("reset_out_sat", out_sat, 0);
        check("reset_out_max4", out_max4, 0);
        @(posedge clk); #1;

        send_beat(8'b0111_0110, 1'b1, 1'b0);
        get_result("single", 3, 1'b0, 3, 1'b0, lat);
        check("single_latency", lat, 0);

        send_beat(8'b0000_0111, 1'b0, 1'b0);
        send_beat(8'b1111_0000, 1'b1, 1'b0);
        get_result("span", 7, 1'b0, 7, 1'b0, lat);

        for (int b = 0; b < 4; b++) begin
            send_beat(8'hFF, (b == 3), 1'b0);
            if (b != 3) repeat (2) begin @(posedge clk); #1; end
        end
        get_result("gaps", 32, 1'b0, 15, 1'b1, lat);

        send_beat(8'b1000_0001, 1'b0, 1'b1);
        send_beat(8'b1111_1111, 1'b1, 1'b0);
        get_result("zeros", 6, 1'b0, 6, 1'b0, lat);

        send_beat(8'b1100_1110, 1'b1, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b1; count_zeros = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_max", out_max, 3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_beat(8'hF0, 1'b1, 1'b0);
        get_result("after_bp", 4, 1'b0, 4, 1'b0, lat);

        for (int b = 0; b < 3; b++) send_beat(8'hFF, (b == 2), 1'b0);
        get_result("sat3", 24, 1'b0, 15, 1'b1, lat);

        send_beat(8'hFF, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send_beat(8'h01, 1'b1, 1'b0);
        get_result("post_abort", 1, 1'b0, 1, 1'b0, lat);

        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: in_data = 8'hFF;
                1: in_data = 8'h00;
                default: in_data = 8'($urandom);
            endcase
            in_last = ($urandom_range(0, 4) == 0);
            count_zeros = $urandom_range(0, 1) != 0;
            out_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/longest_run_stream_tracker.md
Name: longest_run_stream_tracker

Overview:
Streaming successor to the 8-bit combinational ones-string counter. It accepts a frame of WIDTH-bit words over a valid/ready handshake and reports the longest run of consecutive ones, or zeros in zeros mode, across the whole frame. Runs that span word boundaries are counted as one run. The block sits between a packet source and the ALU status/statistics path; one result is produced per frame.

Parameters:
WIDTH, 8, data bits per beat (>= 2)
CNT_W, 16, result counter width; must satisfy CNT_W >= $clog2(WIDTH+1); counts saturate at 2**CNT_W-1 (MAXC)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  beat data; bit WIDTH-1 is earliest in stream order (MSB first)
in_last  input  1  final beat of frame
count_zeros  input  1  1 = measure zero runs; sampled on first beat of frame only
out_valid  output  1  result valid
out_ready  input  1  result consumer ready
out_max  output  CNT_W  longest run length in frame
out_sat  output  1  saturation occurred during frame

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: out_valid=0, out_max=0, out_sat=0, state=IDLE, internal carry/max/mode cleared. in_ready=0 while reset is high.
- Handshake: a beat is accepted when in_valid && in_ready. A result is taken when out_valid && out_ready.
- States: IDLE (no frame open), ACCUM (frame open), DONE (result held). in_ready = !reset && state!=DONE.
- IDLE:
  - Accepted beat latches mode <= count_zeros.
  - Carry and max start from 0.
  - With in_last -> DONE (single-beat frame is legal); otherwise -> ACCUM.
- ACCUM:
  - Accepted beats update accumulators.
  - count_zeros is ignored.
  - in_last -> DONE.
- DONE:
  - out_valid=1; out_max/out_sat stable until out_ready.
  - On out_ready -> IDLE; out_valid falls the next cycle.
  - in_ready=0, so in_valid is ignored.
- Per-beat math:
  - Effective data d = mode ? ~in_data : in_data.
  - pre = count of leading ones from MSB.
  - suf = count of trailing ones from LSB.
  - wmax = longest run inside d.
  - all = (d == all ones).
  - new_max = max(max, carry+pre, wmax).
  - new_carry = all ? carry+WIDTH : suf.
  - All adds saturate at MAXC; any saturation sets the frame's sat flag.
- Result registers: on the last beat, out_max <= new_max and out_sat <= sat | this-beat saturation. out_valid rises the cycle after the last beat is accepted (latency 1).
- Accumulator clear: accumulators clear on entering IDLE. Old out_max/out_sat values may persist while out_valid=0; the bench must not check them then.
- Throughput: one beat per cycle in ACCUM. One idle cycle per frame at minimum (the DONE state).
- Gaps: in_valid low mid-frame is a gap; state and accumulators hold.
- Reset mid-frame or in DONE: the partial frame or pending result is discarded with no output. The next accepted beat starts a new frame.
- Count range: out_max=0 is legal (frame with no matching bits).

Decomposition:
- Package longest_run_pkg holds:
  - state_t enum {IDLE, ACCUM, DONE}
  - a sat_add function (CNT_W-parametrised via a localparam in the caller, or written generically)
  - a max3 helper
- Sub-module run_word_analyzer (WIDTH, CNT_W): purely combinational.
  - Input: d.
  - Outputs: pre, suf, wmax, all.
- The top level holds the FSM, accumulators and handshake.

Test Plan:
- Single beat 8'b0111_0110, in_last=1, count_zeros=0 -> out_valid one cycle later, out_max=3, out_sat=0.
- Spanning run: beats 8'b0000_0111 then 8'b1111_0000 (last) -> out_max=7. The 3+4 boundary join must be counted.
- Four beats 8'hFF, with in_valid gaps of 2 cycles between beats, last on the 4th -> out_max=32, out_sat=0.
- Zeros mode: count_zeros=1 on beat 1 (8'b1000_0001), count_zeros=0 on beat 2 (8'b1111_1111, last) -> mode held, out_max=6.
- Backpressure: after a result, hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_valid stays 1, out_max stable, in_ready=0, no beat consumed. Then out_ready=1 -> IDLE, and the next frame is accepted.
- CNT_W=4 build: three beats 8'hFF -> out_max=15, out_sat=1. Then reset asserted mid-frame after beat 1 of a new frame, followed by a frame 8'h01 (last) -> out_max=1, out_sat=0, with no output for the aborted frame.
